tdm_frame_receiver: RTL and testbench

//  Downstream consumer of the 8-channel select-routed transmission stage. Scans select lines
//  A,B,C through channels 0..7, holds each slot DWELL cycles, samples the routed output line of
//  the selected channel and assembles an 8-bit frame. Compares the frame with the word fed to
//  the transmission stage and checks that every unselected line idles high.

---
 rtl/tdm_frame_receiver.sv | 128 ++++++++++++
 tb/tb_tdm_frame_receiver.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/tdm_frame_receiver.sv
//==============================================================================
// Module : tdm_frame_receiver
// Scans the 8 select-routed channels, samples one line per slot and assembles
// a frame; reports bit errors against the expected word and idle-line faults.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tdm_frame_receiver #(
  parameter int DWELL = 4
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic       iStart,
  input  logic [7:0] iExpected,
  input  logic [7:0] iLine,
  output logic       oA,
  output logic       oB,
  output logic       oC,
  output logic       oBusy,
  output logic [7:0] oWord,
  output logic       oValid,
  output logic [7:0] oErrMask,
  output logic       oIdleFault
);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_SCAN = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;

  localparam logic [3:0] c_DWELL_LAST = 4'(DWELL - 1);

  logic [1:0] r_state;
  logic [2:0] r_slot;
  logic [3:0] r_dwell;
  logic [7:0] r_expected;
  logic [7:0] r_shadow;
  logic [2:0] r_sel;
  logic       r_busy;
  logic [7:0] r_word;
  logic       r_valid;
  logic [7:0] r_errmask;
  logic       r_idle_fault;

  logic       w_sample;
  logic [7:0] w_sel_onehot;
  logic       w_idle_bad;

  assign w_sample     = (r_state == c_SCAN) && (r_dwell == c_DWELL_LAST);
  assign w_sel_onehot = 8'b0000_0001 << r_slot;
  // Any unselected line pulled low is a routing/idle fault
  assign w_idle_bad   = |(~iLine & ~w_sel_onehot);

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_state      <= c_IDLE;
      r_slot       <= 3'd0;
      r_dwell      <= 4'd0;
      r_expected   <= 8'd0;
      r_shadow     <= 8'd0;
      r_sel        <= 3'd0;
      r_busy       <= 1'b0;
      r_word       <= 8'd0;
      r_valid      <= 1'b0;
      r_errmask    <= 8'd0;
      r_idle_fault <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        c_IDLE: begin
          r_sel <= 3'd0;
          if (iStart) begin
            r_state      <= c_SCAN;
            r_expected   <= iExpected;
            r_idle_fault <= 1'b0;
            r_slot       <= 3'd0;
            r_dwell      <= 4'd0;
            r_busy       <= 1'b1;
          end else begin
            r_busy <= 1'b0;
          end
        end
        c_SCAN: begin
          if (w_sample) begin
            r_shadow[r_slot] <= iLine[r_slot];
            if (w_idle_bad) begin
              r_idle_fault <= 1'b1;
            end
            r_dwell <= 4'd0;
            if (r_slot == 3'd7) begin
              r_state <= c_DONE;
              r_sel   <= 3'd0;
            end else begin
              r_slot <= r_slot + 3'd1;
              r_sel  <= r_slot + 3'd1;
            end
          end else begin
            r_dwell <= r_dwell + 4'd1;
          end
        end
        c_DONE: begin
          // Busy stays high through the result cycle and drops in IDLE
          r_word    <= r_shadow;
          r_errmask <= r_shadow ^ r_expected;
          r_valid   <= 1'b1;
          r_slot    <= 3'd0;
          r_sel     <= 3'd0;
          r_state   <= c_IDLE;
        end
        default: begin
          r_state <= c_IDLE;
        end
      endcase
    end
  end

  assign oA         = r_sel[2];
  assign oB         = r_sel[1];
  assign oC         = r_sel[0];
  assign oBusy      = r_busy;
  assign oWord      = r_word;
  assign oValid     = r_valid;
  assign oErrMask   = r_errmask;
  assign oIdleFault = r_idle_fault;

endmodule

`default_nettype wire

// File: tb/tb_tdm_frame_receiver.sv
//==============================================================================
// Module : tb_tdm_frame_receiver
// Randomized frames against a behavioural model of the transmission stage.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_tdm_frame_receiver;

  localparam int D = 4;

  logic clk;
  logic rst;

  // DWELL=4 instance
  logic       start4;
  logic [7:0] exp4;
  logic [7:0] line4;
  logic       a4, b4, c4, busy4, valid4, fault4;
  logic [7:0] word4, err4;
  logic [2:0] sel4;

  // DWELL=1 instance
  logic       start1;
  logic [7:0] exp1;
  logic [7:0] line1;
  logic       a1, b1, c1, busy1, valid1, fault1;
  logic [7:0] word1, err1;
  logic [2:0] sel1;

  // Transmission-stage model controls
  logic [7:0] tx4, flip4, tx1;
  logic       inj4;
  logic [2:0] islot4, ich4;

  int n_checks;
  int n_errors;

  tdm_frame_receiver #(.DWELL(D)) u_dut4 (
    .iClk(clk), .iRst(rst), .iStart(start4), .iExpected(exp4), .iLine(line4),
    .oA(a4), .oB(b4), .oC(c4), .oBusy(busy4), .oWord(word4), .oValid(valid4),
    .oErrMask(err4), .oIdleFault(fault4)
  );

  tdm_frame_receiver #(.DWELL(1)) u_dut1 (
    .iClk(clk), .iRst(rst), .iStart(start1), .iExpected(exp1), .iLine(line1),
    .oA(a1), .oB(b1), .oC(c1), .oBusy(busy1), .oWord(word1), .oValid(valid1),
    .oErrMask(err1), .oIdleFault(fault1)
  );

  assign sel4 = {a4, b4, c4};
  assign sel1 = {a1, b1, c1};

  // Selected channel carries its data bit (optionally corrupted); others idle high
  always_comb begin
    line4 = 8'hFF;
    line4[sel4] = tx4[sel4] ^ flip4[sel4];
    if (inj4 && (sel4 == islot4)) line4[ich4] = 1'b0;
  end

  always_comb begin
    line1 = 8'hFF;
    line1[sel1] = tx1[sel1];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic run_frame(input logic [7:0] tx, input logic [7:0] flip, input logic inj,
                           input logic [2:0] islot, input logic [2:0] ich, input logic mid);
    tx4 = tx; flip4 = flip; inj4 = inj; islot4 = islot; ich4 = ich;
    exp4 = tx;
    start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    exp4 = ~tx;
    chk("busy_start", busy4, 1);
    chk("sel_start", sel4, 0);
    chk("fault_clr", fault4, 0);
    for (int k = 1; k <= 8*D + 2; k++) begin
      @(posedge clk); #1;
      chk("sel", sel4, (k < 8*D) ? k / D : 0);
      chk("valid", valid4, k == 8*D + 1);
      chk("busy", busy4, k <= 8*D + 1);
      chk("ifault", fault4, inj && (k >= (int'(islot) + 1) * D));
      if (k == 8*D + 1) begin
        chk("word", word4, tx ^ flip);
        chk("errmask", err4, flip);
      end
      if (mid && k == 4*D) begin
        start4 = 1'b1;
        exp4 = 8'h00;
      end
      if (mid && k == 4*D + 1) start4 = 1'b0;
    end
  endtask

  initial begin
    int seen;
    logic [2:0] rs, rc;
    n_checks = 0; n_errors = 0;
    rst = 1'b1;
    start4 = 0; exp4 = 0; start1 = 0; exp1 = 0;
    tx4 = 0; flip4 = 0; inj4 = 0; islot4 = 0; ich4 = 1; tx1 = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_word", word4, 0);
    chk("rst_err", err4, 0);
    chk("rst_valid", valid4, 0);
    chk("rst_busy", busy4, 0);
    chk("rst_sel", sel4, 0);
    chk("rst_fault", fault4, 0);
    chk("rst_busy1", busy1, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Loopback, bit error, idle fault, start while busy
    run_frame(8'hA5, 8'h00, 1'b0, 3'd0, 3'd1, 1'b0);
    run_frame(8'hFF, 8'h40, 1'b0, 3'd0, 3'd1, 1'b0);
    run_frame(8'h5A, 8'h00, 1'b1, 3'd5, 3'd2, 1'b0);
    run_frame(8'h5A, 8'h00, 1'b0, 3'd0, 3'd1, 1'b1);

    for (int f = 0; f < 10; f++) begin
      rs = 3'($urandom_range(0, 7));
      rc = 3'(rs + 3'($urandom_range(1, 7)));
      run_frame(8'($urandom), ($urandom_range(0, 1) != 0) ? 8'($urandom) : 8'h00,
                1'($urandom), rs, rc, 1'($urandom));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end

    // Reset in the middle of slot 3 discards the frame
    tx4 = 8'h11; flip4 = 0; inj4 = 1; islot4 = 3'd1; ich4 = 3'd6;
    exp4 = 8'h11; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    repeat (3*D + 1) @(posedge clk);
    #1;
    chk("pre_rst_sel", sel4, 3);
    chk("pre_rst_fault", fault4, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_sel", sel4, 0);
    chk("mid_rst_busy", busy4, 0);
    chk("mid_rst_fault", fault4, 0);
    chk("mid_rst_word", word4, 0);
    chk("mid_rst_err", err4, 0);
    chk("mid_rst_valid", valid4, 0);
    rst = 1'b0;
    inj4 = 0;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (valid4 || busy4) seen++;
    end
    chk("no_valid_after_rst", seen, 0);

    // DWELL=1 back-to-back frames with start held high
    tx1 = 8'h3C; exp1 = 8'h3C; start1 = 1'b1;
    @(posedge clk); #1;
    seen = 0;
    for (int k = 1; k <= 25; k++) begin
      @(posedge clk); #1;
      chk("d1_valid", valid1, (k == 9) || (k == 19));
      if (k == 9)  chk("d1_word0", word1, 8'h3C);
      if (k == 19) chk("d1_word1", word1, 8'hC3);
      if (k == 9 || k == 19) chk("d1_err", err1, 0);
      if (k < 8) chk("d1_sel", sel1, k);
      if (k == 5) exp1 = 8'hC3;
      if (k == 10) tx1 = 8'hC3;
      if (k == 11) start1 = 1'b0;
    end
    chk("d1_fault", fault1, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
